// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encodings, digit geometry and elaboration-time sizing helpers.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int          BCD_DIG_W   = 4;
   localparam logic [3:0]  ADD3_THRESH = 4'd5;

   // Largest decimal value representable with n BCD digits, plus one.
   function automatic longint pow10(input int n);
      longint r;
      r = 1;
      for (int i = 0; i < n; i++) begin
         r = r * 10;
      end
      return r;
   endfunction

   function automatic longint max_bin(input int width);
      return (longint'(1) << width) - 1;
   endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Double-dabble correction for one BCD digit: digits of 5 or more get +3
// so the following left shift carries correctly into the next digit.
module bcd_add3_cell
   import bcd_pkg::*;
(
   input  logic [BCD_DIG_W-1:0] digit_in,
   output logic [BCD_DIG_W-1:0] digit_out
);

   always_comb begin
      digit_out = digit_in;
      if (digit_in >= ADD3_THRESH) begin
         digit_out = digit_in + 4'd3;
      end
   end

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Iterative binary-to-BCD converter: one shift-and-add-3 step per clock,
// start/busy/done handshake, result held in bcd_out between conversions.
module bin2bcd_seq_ctrl
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [WIDTH-1:0]          bin_in,
   output logic                      busy,
   output logic                      done,
   output logic [BCD_DIG_W*DIGITS-1:0] bcd_out
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int BCD_W = BCD_DIG_W * DIGITS;

   if (pow10(DIGITS) <= max_bin(WIDTH)) begin : g_bad_digits
      $error("bin2bcd_seq_ctrl: DIGITS=%0d cannot hold 2**%0d-1", DIGITS, WIDTH);
   end

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   bin_sr_q, bin_sr_d;
   logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
   logic [BCD_W-1:0]   bcd_adj;
   logic [BCD_W+WIDTH-1:0] shifted;

   for (genvar i = 0; i < DIGITS; i++) begin : g_add3
      bcd_add3_cell u_cell (
         .digit_in  (bcd_sr_q[i*BCD_DIG_W +: BCD_DIG_W]),
         .digit_out (bcd_adj[i*BCD_DIG_W +: BCD_DIG_W])
      );
   end

   // Corrected digits and the binary operand shift together as one register.
   assign shifted = {bcd_adj, bin_sr_q} << 1;

   always_comb begin
      state_d   = state_q;
      bin_sr_d  = bin_sr_q;
      bcd_sr_d  = bcd_sr_q;
      cnt_d     = cnt_q;
      bcd_out_d = bcd_out_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               bin_sr_d = bin_in;
               bcd_sr_d = '0;
               cnt_d    = '0;
               state_d  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            {bcd_sr_d, bin_sr_d} = shifted;
            cnt_d = cnt_q + CNT_W'(1);
            // Capture on the last shift so bcd_out is already valid while done is high.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               bcd_out_d = shifted[BCD_W+WIDTH-1:WIDTH];
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bin_sr_q  <= '0;
         bcd_sr_q  <= '0;
         cnt_q     <= '0;
         bcd_out_q <= '0;
      end else begin
         state_q   <= state_d;
         bin_sr_q  <= bin_sr_d;
         bcd_sr_q  <= bcd_sr_d;
         cnt_q     <= cnt_d;
         bcd_out_q <= bcd_out_d;
      end
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_DONE);
   assign bcd_out = bcd_out_q;

endmodule
